// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for sync_fifo: pops a show-ahead FIFO into a 2-entry head/skid buffer.
// Optional accepted-beat counter enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_fifo_rdata,
   input  logic             i_fifo_not_empty,
   output logic             o_fifo_pop,
   output logic             o_fifo_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_idle,
   output logic [CNT_W-1:0] o_beat_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] head, head_nxt;
   logic [WIDTH-1:0] skid, skid_nxt;
   logic             in_beat;
   logic             out_beat;

   // Pop depends only on registered state and FIFO status, never on i_ready.
   assign o_fifo_pop   = i_rst_n & i_fifo_not_empty & (state != S_TWO) & ~i_flush;
   assign o_fifo_flush = i_flush;
   assign o_valid      = (state != S_EMPTY);
   assign o_data       = head;
   assign o_idle       = (state == S_EMPTY) & ~i_fifo_not_empty;

   assign in_beat  = o_fifo_pop;
   assign out_beat = o_valid & i_ready;

   always_comb begin
      state_nxt = state;
      head_nxt  = head;
      skid_nxt  = skid;
      if (i_flush) begin
         state_nxt = S_EMPTY;
         head_nxt  = '0;
         skid_nxt  = '0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (in_beat) begin
                  head_nxt  = i_fifo_rdata;
                  state_nxt = S_ONE;
               end
            end
            S_ONE: begin
               if (in_beat && out_beat) begin
                  head_nxt = i_fifo_rdata;
               end else if (in_beat) begin
                  skid_nxt  = i_fifo_rdata;
                  state_nxt = S_TWO;
               end else if (out_beat) begin
                  state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               if (out_beat) begin
                  head_nxt  = skid;
                  state_nxt = S_ONE;
               end
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         state <= state_nxt;
         head  <= head_nxt;
         skid  <= skid_nxt;
      end
   end

`ifdef FIFO_RD_STREAM_CNT_EN
   logic [CNT_W-1:0] beat_cnt;

   // Flush wins over a transfer in the same cycle; wraps naturally.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         beat_cnt <= '0;
      end else if (i_flush) begin
         beat_cnt <= '0;
      end else if (out_beat) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

   assign o_beat_cnt = beat_cnt;
`else
   assign o_beat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a small show-ahead FIFO model on the read side.
// Beat-count expectations follow FIFO_RD_STREAM_CNT_EN.
module tb_fifo_rd_stream;

   localparam int WIDTH = 16;
   localparam int CNT_W = 16;
`ifdef FIFO_RD_STREAM_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             ready;
   logic             push;
   logic [WIDTH-1:0] pdata;

   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_not_empty;
   logic             fifo_pop;
   logic             fifo_flush;
   logic             valid;
   logic [WIDTH-1:0] data;
   logic             idle;
   logic [CNT_W-1:0] beat_cnt;

   int checks = 0;
   int errors = 0;
   int pop_cnt = 0;

   fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_flush          (flush),
      .i_fifo_rdata     (fifo_rdata),
      .i_fifo_not_empty (fifo_not_empty),
      .o_fifo_pop       (fifo_pop),
      .o_fifo_flush     (fifo_flush),
      .o_valid          (valid),
      .i_ready          (ready),
      .o_data           (data),
      .o_idle           (idle),
      .o_beat_cnt       (beat_cnt)
   );

   always #5 clk = ~clk;

   // Show-ahead FIFO model
   logic [WIDTH-1:0] mem [0:63];
   logic [5:0]       wp, rp;
   logic [6:0]       cnt;

   assign fifo_rdata     = mem[rp];
   assign fifo_not_empty = (cnt != 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (fifo_flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) begin
            mem[wp] <= pdata;
            wp      <= wp + 6'd1;
         end
         if (fifo_pop) rp <= rp + 6'd1;
         cnt <= cnt + 7'(push) - 7'(fifo_pop);
      end
   end

   always @(posedge clk) begin
      if (fifo_pop) pop_cnt <= pop_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] exp_cnt(input int n);
      return CNT_EN ? 32'(n) : 32'd0;
   endfunction

   logic [WIDTH-1:0] w4 [0:3];
   logic [WIDTH-1:0] w8 [0:7];
   int               base;
   int               idx;
   logic             prev_hold;
   logic [WIDTH-1:0] prev_data;

   initial begin
      clk = 0; rst_n = 0; flush = 0; ready = 0; push = 0; pdata = '0;
      w4[0] = 16'hA000; w4[1] = 16'hA001; w4[2] = 16'hA002; w4[3] = 16'hA003;
      for (int i = 0; i < 8; i++) w8[i] = 16'hC000 + 16'(i * 16'h0111);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_pop", fifo_pop, 0);
      check("rst_idle", idle, 1);
      check("rst_data", data, 0);
      check("rst_cnt", beat_cnt, 0);
      rst_n = 1;
      tick();
      check("post_rst_idle", idle, 1);

      // Three words streamed with ready high
      ready = 1;
      push = 1; pdata = 16'h1111;
      tick();
      check("t2_pop0", fifo_pop, 1);
      check("t2_valid0", valid, 0);
      pdata = 16'h2222;
      tick();
      check("t2_valid1", valid, 1);
      check("t2_data1", data, 16'h1111);
      check("t2_pop1", fifo_pop, 1);
      pdata = 16'h3333;
      tick();
      push = 0;
      check("t2_data2", data, 16'h2222);
      check("t2_pop2", fifo_pop, 1);
      tick();
      check("t2_data3", data, 16'h3333);
      check("t2_pop3", fifo_pop, 0);
      tick();
      check("t2_valid_end", valid, 0);
      check("t2_cnt", beat_cnt, exp_cnt(3));

      // Back-pressure: four words, only two popped
      ready = 0;
      base = pop_cnt;
      push = 1;
      for (int i = 0; i < 4; i++) begin
         pdata = w4[i];
         tick();
      end
      push = 0;
      repeat (3) tick();
      check("t3_pops", pop_cnt - base, 2);
      check("t3_pop_stall", fifo_pop, 0);
      check("t3_fifo_ne", fifo_not_empty, 1);
      check("t3_valid", valid, 1);
      check("t3_hold", data, w4[0]);
      ready = 1;
      for (int i = 0; i < 4; i++) begin
         check("t3_drain_valid", valid, 1);
         check("t3_drain_data", data, w4[i]);
         tick();
      end
      check("t3_valid_end", valid, 0);
      check("t3_cnt", beat_cnt, exp_cnt(7));

      // Ready toggling over eight words
      ready = 0;
      push = 1;
      for (int i = 0; i < 8; i++) begin
         pdata = w8[i];
         tick();
      end
      push = 0;
      repeat (2) tick();
      idx = 0;
      prev_hold = 0;
      prev_data = '0;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         if (prev_hold) check("t4_stable", data, prev_data);
         ready = ~c[0];
         if (valid && ready) begin
            check("t4_data", data, w8[idx]);
            idx++;
         end
         prev_hold = valid & ~ready;
         prev_data = data;
         tick();
      end
      check("t4_count", idx, 8);
      check("t4_cnt", beat_cnt, exp_cnt(15));

      // Flush while holding two entries
      ready = 0;
      push = 1;
      for (int i = 0; i < 4; i++) begin
         pdata = w4[i] ^ 16'h0F0F;
         tick();
      end
      push = 0;
      repeat (2) tick();
      check("t5_pre_valid", valid, 1);
      check("t5_pre_pop", fifo_pop, 0);
      ready = 1;
      flush = 1;
      #1;
      check("t5_fifo_flush", fifo_flush, 1);
      check("t5_pop_blocked", fifo_pop, 0);
      tick();
      flush = 0;
      #1;
      check("t5_valid", valid, 0);
      check("t5_idle", idle, 1);
      check("t5_data", data, 0);
      check("t5_cnt", beat_cnt, 0);
      check("t5_fifo_empty", fifo_not_empty, 0);
      @(negedge clk);

      // Asynchronous reset mid-stream
      ready = 0;
      push = 1; pdata = 16'hA5A5;
      tick();
      pdata = 16'h5A5A;
      tick();
      push = 0;
      repeat (2) tick();
      check("t6_pre_valid", valid, 1);
      check("t6_pre_data", data, 16'hA5A5);
      #2 rst_n = 0;
      #1;
      check("t6_async_valid", valid, 0);
      check("t6_async_data", data, 0);
      @(negedge clk);
      rst_n = 1;
      ready = 1;
      push = 1; pdata = 16'hBEEF;
      tick();
      push = 0;
      tick();
      check("t6_new_valid", valid, 1);
      check("t6_new_data", data, 16'hBEEF);
      tick();
      check("t6_valid_end", valid, 0);
      check("t6_cnt", beat_cnt, exp_cnt(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
